vga_sync: RTL
=============

# vga_sync

Generates the 640x480@60 Hz VGA raster timing that drives every pixel-generation block in the design. It produces the pixel coordinates `pixel_x`/`pixel_y`, the pixel-rate enable `p_tick`, `video_on`, and the active-low `hsync`/`vsync` for the connector. Text and graphics overlays consume the coordinates. Their RGB outputs are gated by `video_on` downstream.

## Interface
- `DIV`, 4, system clocks per pixel; must be ≥1 (4 → 25 MHz pixels from 100 MHz `clk`).
- `H_DISP`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48, horizontal region lengths in pixels.
- `V_DISP`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33, vertical region lengths in lines.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `p_tick`  out  1  one-`clk`-wide pixel enable, once every `DIV` clocks.
- `pixel_x`  out  10  current column, 0..H_TOTAL-1.
- `pixel_y`  out  10  current row, 0..V_TOTAL-1.
- `video_on`  out  1  high while `pixel_x`<H_DISP and `pixel_y`<V_DISP.
- `hsync`  out  1  active-low horizontal sync.
- `vsync`  out  1  active-low vertical sync.
- `line_end`  out  1  `p_tick` && `pixel_x`==H_TOTAL-1.
- `frame_end`  out  1  `line_end` && `pixel_y`==V_TOTAL-1.

## Operation
- H_TOTAL = sum of the H parameters (800). V_TOTAL = sum of the V parameters (525).
- Divider `div_cnt`:
  - Counts 0..DIV-1 and wraps.
  - `p_tick` is a decode of `div_cnt`==DIV-1.
  - For DIV=1, `p_tick` is constantly 1 out of reset.
- Horizontal counter:
  - Advances only on edges where `p_tick`=1.
  - Wraps H_TOTAL-1 → 0.
- Vertical counter:
  - Advances on the same edge the horizontal counter wraps.
  - Wraps V_TOTAL-1 → 0.
  - Holds on all other edges.
- `pixel_x`/`pixel_y` are the counter registers themselves.
- Registered outputs:
  - `hsync`, `vsync` and `video_on` are computed from the counters' next-state values and registered.
  - Result: they change on the same edge as the counters, always consistent with the `pixel_x`/`pixel_y` shown in that cycle, and glitch-free.
- Sync windows:
  - `hsync`=0 iff H_DISP+H_FP ≤ `pixel_x` ≤ H_DISP+H_FP+H_SYNC-1 (656..751).
  - `vsync`=0 iff V_DISP+V_FP ≤ `pixel_y` ≤ V_DISP+V_FP+V_SYNC-1 (490..491).
- `line_end` and `frame_end` are combinational decodes; they are high for exactly one `clk` per line and per frame respectively.

## Timing
- Reset values (async, while `reset_n`=0):
  - `div_cnt`=0, `pixel_x`=0, `pixel_y`=0.
  - `hsync`=1, `vsync`=1, `video_on`=0.
  - `p_tick`=0 unless DIV=1; `line_end`=0, `frame_end`=0.
- `video_on` stays 0 until the first `p_tick` edge after reset. This deliberately suppresses pixel (0,0) of the first frame only.
- First tick after reset release:
  - First `p_tick` is high in clock cycle DIV-1, counted from 0 at the first edge after release.
  - On that edge `pixel_x` goes 0→1 and `video_on` goes to 1.
- Coordinate hold: each (`pixel_x`,`pixel_y`) value holds for exactly DIV clocks.
- Frame period: H_TOTAL·V_TOTAL·DIV clocks = 1 680 000 at DIV=4.
- Simultaneous wraps: at x=799, y=524 with `p_tick`=1, both counters wrap to 0 on that one edge and `frame_end` is high in that cycle.
- Reset asserted mid-frame: all state returns to its reset value immediately, without waiting for `clk`. After release, timing restarts exactly as from power-up.
- Latency: zero clocks from counter value to `hsync`/`vsync`/`video_on` (aligned, as above).

## Structure
- Shared package `vga_timing_pkg` holds:
  - the default H/V region constants;
  - the derived H_TOTAL/V_TOTAL;
  - the sync polarity constant, active low.
- The overlay/text blocks import the same package for display width and height.
- One sub-module, `pix_tick_gen`:
  - parameter `DIV`; ports `clk`, `reset_n`, `p_tick`;
  - contains the divider only.
- Counters, sync generation and decodes stay in `vga_sync`.

## Test plan
- Reset values: hold `reset_n`=0 for 5 clks → `pixel_x`=0, `pixel_y`=0, `hsync`=1, `vsync`=1, `video_on`=0, `p_tick`=0.
- Tick cadence: release reset with DIV=4 → `p_tick` high in cycles 3, 7, 11, …; `pixel_x` reads 1 from cycle 4 and 2 from cycle 8.
- Line: run one line → `hsync` is low for exactly 96·4=384 clks, starting on the edge where `pixel_x` becomes 656; `video_on` is low from x=640; `line_end` pulses once, at x=799.
- Frame: run a full frame → `vsync` is low for exactly 2 lines (y=490..491); the frame lasts 1 680 000 clks; `frame_end` fires once, then `pixel_x`=`pixel_y`=0 on the next edge.
- Mid-frame reset: assert `reset_n`=0 asynchronously at y=300, x=400, between clock edges → outputs return to reset values before the next edge; after release, the first `p_tick` is again in cycle 3.
- DIV=1 build: `p_tick` is constantly 1 after reset; `pixel_x` increments every clk; the frame lasts 420 000 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants and sync helpers
package vga_timing_pkg;
  localparam int H_DISP  = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_DISP  = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int COORD_W = 10;
  localparam logic SYNC_ACTIVE = 1'b0;

  // True when coordinate v lies in [lo, lo+len).
  function automatic logic in_window(input logic [COORD_W-1:0] v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction
endpackage

// File: rtl/pix_tick_gen.sv
// pix_tick_gen: divides clk down to a one-cycle pixel enable every DIV clocks
module pix_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt_q, div_cnt_d;

  // Next divider value: count 0..DIV-1 and wrap.
  always_comb div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;

  // Divider register; with DIV=1 it is stuck at 0 so the tick is always high.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) div_cnt_q <= '0;
    else          div_cnt_q <= div_cnt_d;

  assign p_tick = (div_cnt_q == LAST);
endmodule

// File: rtl/vga_sync.sv
// vga_sync: raster counters, registered sync/blanking and line/frame decodes
module vga_sync #(
  parameter int DIV    = 4,
  parameter int H_DISP = vga_timing_pkg::H_DISP,
  parameter int H_FP   = vga_timing_pkg::H_FP,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BP   = vga_timing_pkg::H_BP,
  parameter int V_DISP = vga_timing_pkg::V_DISP,
  parameter int V_FP   = vga_timing_pkg::V_FP,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BP   = vga_timing_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_end
);
  import vga_timing_pkg::*;

  localparam int HT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int VT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hs_q, hs_d, vs_q, vs_d, vid_q, vid_d;

  pix_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .p_tick (p_tick)
  );

  // Next raster position and the sync/blank levels that belong to it.
  always_comb begin
    x_d   = (x_q == H_LAST) ? '0 : x_q + 10'd1;
    y_d   = (x_q != H_LAST) ? y_q : (y_q == V_LAST) ? '0 : y_q + 10'd1;
    hs_d  = in_window(x_d, H_DISP + H_FP, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_d  = in_window(y_d, V_DISP + V_FP, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vid_d = (int'(x_d) < H_DISP) && (int'(y_d) < V_DISP);
  end

  // Counters and outputs move together on pixel ticks only, keeping them aligned;
  // video_on therefore stays low until the first tick after reset.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= ~SYNC_ACTIVE;
      vs_q  <= ~SYNC_ACTIVE;
      vid_q <= 1'b0;
    end else if (p_tick) begin
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      vid_q <= vid_d;
    end

  assign pixel_x   = x_q;
  assign pixel_y   = y_q;
  assign hsync     = hs_q;
  assign vsync     = vs_q;
  assign video_on  = vid_q;
  assign line_end  = p_tick && (x_q == H_LAST);
  assign frame_end = line_end && (y_q == V_LAST);
endmodule
